fare_display_ctrl: RTL
======================

// Module: fare_display_ctrl
// PURPOSE
//   Sequencing controller between the taxi fare counter and the 3-digit 7-segment display.
//   Accepts a 10-bit fare over a valid/ready handshake.
//   Converts the fare to BCD with a sequential shift-add-3 engine, one bit per cycle, so no dividers are needed.
//   Scans the shared segment bus across three common-anode digits, with optional leading-zero blanking.
// PARAMETERS
//   SCAN_DIV  50000  clk cycles per digit slot (>=2); prescaler width = $clog2(SCAN_DIV)
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   reset, asynchronous, active-high
//   fare_in     in   10  fare value (binary, 0..1023)
//   fare_valid  in   1   fare_in valid; source holds until accepted
//   fare_ready  out  1   controller can accept; =1 only in IDLE
//   blank_en    in   1   1 = blank leading zeros (sampled live, not latched)
//   busy        out  1   1 while in CONV or LOAD
//   seg_n       out  7   segments {g,f,e,d,c,b,a}, active-low
//   dig_n       out  3   digit enables {hundreds,tens,units}, active-low, one-hot
// BEHAVIOUR
//   Reset values:
//   - state=IDLE, bit counter=0, shift reg=0, display BCD regs H/T/U=0, ovf=0.
//   - Prescaler=0, digit idx=0 (units).
//   - Outputs: fare_ready=1, busy=0, dig_n=3'b110, seg_n=7'b1000000 ('0').
//   FSM (IDLE, CONV, LOAD):
//   - IDLE: accept when fare_valid & fare_ready at edge T.
//     - Capture fare_in into the 22-bit shift reg {bcd[11:0], bin[9:0]}.
//     - Go to CONV.
//   - CONV: one iteration per cycle (edges T+1..T+10).
//     - Add 3 to each BCD nibble >=5, then shift left by 1.
//     - After the 10th iteration, go to LOAD.
//   - LOAD (edge T+11):
//     - Copy BCD nibbles to H/T/U.
//     - Set ovf=(captured fare>999).
//     - Go to IDLE.
//     - H/T/U/ovf update atomically: a digit is never shown mixing old and new values.
//   - Latency: accept edge -> display regs valid is exactly 11 cycles. fare_ready is low for those 11 cycles.
//   - fare_valid is ignored while not IDLE. Back-to-back accepts are spaced 12 cycles apart minimum.
//   - A fare held valid across LOAD is accepted on the first IDLE cycle.
//   - fare_ready and busy are combinational decodes of state.
//   Scan:
//   - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
//   - On terminal count, idx advances 0->1->2->0 (units->tens->hundreds). The prescaler wraps to 0.
//   - dig_n = ~(3'b001<<idx).
//   - seg_n is combinational from idx, the display regs, ovf and blank_en.
//   - A display update coinciding with a digit advance shows the new value on the new digit in the same cycle.
//   Digit encoding (active-low):
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//     5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//   - blank=1111111, dash=0111111.
//   Priority per digit:
//   - ovf -> dash on all three digits (fares 1000..1023).
//   - Else if blank_en:
//     - H blanked if H==0.
//     - T blanked if H==0 and T==0.
//     - U never blanked.
//   - Else decode the BCD value.
//   Reset mid-operation:
//   - Conversion is aborted; no partial value ever reaches H/T/U.
//   - Display returns to the reset values above.
// TESTING
//   1. Release rst -> fare_ready=1, busy=0, dig_n=110, seg_n=1000000.
//   2. SCAN_DIV=4, fare 357 -> busy high 11 cycles, then ready.
//      dig_n 110/101/011 each 4 cycles; seg_n 1111000/0010010/0110000 (7,5,3).
//   3. fare 5, blank_en=1 -> tens/hundreds seg_n=1111111, units 0010010.
//      With blank_en=0 -> tens/hundreds 1000000.
//   4. fare 1000 and fare 1023 -> all digits 0111111.
//      Then fare 999 -> all 0010000, ovf cleared.
//   5. fare 120 accepted, fare 456 presented during CONV and held -> 120 shown first.
//      456 accepted on the cycle after LOAD; 456 shown 12 cycles after the 120 LOAD.
//   6. Display 357, then start fare 842 and assert rst at accept+5 -> display 000, IDLE.
//      A new fare after release converts correctly.

Source files
------------

// File: rtl/fare_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fare_display_ctrl
//  Purpose  : Sequencing controller between the taxi fare counter and a
//             3-digit common-anode 7-segment display. A 10-bit fare is taken
//             over a valid/ready handshake, converted to BCD by a sequential
//             shift-add-3 engine (one bit per cycle), and shown by scanning
//             the shared segment bus across the three digits, with optional
//             leading-zero blanking. Fares above 999 show dashes.
//  Ports    : clk         - clock, all state on rising edge
//             rst         - asynchronous active-high reset
//             fare_in     - fare value, binary 0..1023
//             fare_valid  - fare_in valid, held by source until accepted
//             fare_ready  - high only while idle (can accept)
//             blank_en    - 1 = blank leading zeros (live, not latched)
//             busy        - high while converting or loading
//             seg_n       - segments {g,f,e,d,c,b,a}, active-low
//             dig_n       - digit enables {hundreds,tens,units}, active-low
//  Revision : 1.0 - initial release
// ============================================================================
module fare_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] fare_in,
  input  logic       fare_valid,
  output logic       fare_ready,
  input  logic       blank_en,
  output logic       busy,
  output logic [6:0] seg_n,
  output logic [2:0] dig_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] c_PRESC_TC = PW'(SCAN_DIV - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CONV = 2'd1;
  localparam logic [1:0] c_LOAD = 2'd2;

  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] c_SEG_DASH  = 7'b0111111;

  logic [1:0]    r_state;
  logic [3:0]    r_bitcnt;
  logic [21:0]   r_shift;     // {bcd[11:0], bin[9:0]}
  logic          r_ovf_pend;  // captured fare > 999, applied at load
  logic [3:0]    r_h;
  logic [3:0]    r_t;
  logic [3:0]    r_u;
  logic          r_ovf;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;

  logic [21:0]   w_adj;
  logic [21:0]   w_next;
  logic [3:0]    w_digit;
  logic          w_blank;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return c_SEG_BLANK;
    endcase
  endfunction

  // One shift-add-3 iteration: correct each BCD nibble, then shift left.
  assign w_adj  = {add3(r_shift[21:18]), add3(r_shift[17:14]),
                   add3(r_shift[13:10]), r_shift[9:0]};
  assign w_next = w_adj << 1;

  assign fare_ready = (r_state == c_IDLE);
  assign busy       = (r_state == c_CONV) || (r_state == c_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_bitcnt   <= 4'd0;
      r_shift    <= 22'd0;
      r_ovf_pend <= 1'b0;
      r_h        <= 4'd0;
      r_t        <= 4'd0;
      r_u        <= 4'd0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (fare_valid) begin
            r_shift    <= {12'd0, fare_in};
            r_ovf_pend <= (fare_in > 10'd999);
            r_bitcnt   <= 4'd0;
            r_state    <= c_CONV;
          end
        end
        c_CONV: begin
          r_shift <= w_next;
          if (r_bitcnt == 4'd9) begin
            r_bitcnt <= 4'd0;
            r_state  <= c_LOAD;
          end else begin
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end
        c_LOAD: begin
          // All display registers change on the same edge.
          r_h     <= r_shift[21:18];
          r_t     <= r_shift[17:14];
          r_u     <= r_shift[13:10];
          r_ovf   <= r_ovf_pend;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Digit scan runs continuously, independent of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (r_presc == c_PRESC_TC) begin
      r_presc <= '0;
      r_idx   <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign dig_n = ~(3'b001 << r_idx);

  always_comb begin
    w_digit = r_u;
    w_blank = 1'b0;
    case (r_idx)
      2'd1: begin
        w_digit = r_t;
        w_blank = blank_en && (r_h == 4'd0) && (r_t == 4'd0);
      end
      2'd2: begin
        w_digit = r_h;
        w_blank = blank_en && (r_h == 4'd0);
      end
      default: begin
        w_digit = r_u;
        w_blank = 1'b0;
      end
    endcase
    if (r_ovf)
      seg_n = c_SEG_DASH;
    else if (w_blank)
      seg_n = c_SEG_BLANK;
    else
      seg_n = decode(w_digit);
  end

endmodule
`default_nettype wire
